// File: rtl/jogo_pkg.sv
// jogo_pkg: state codes shared with the db_estado 7-seg decoder, plus default display timings.
package jogo_pkg;
    localparam logic [3:0] EST_OCIOSO   = 4'd0;
    localparam logic [3:0] EST_ENDERECA = 4'd1;
    localparam logic [3:0] EST_LE       = 4'd2;
    localparam logic [3:0] EST_ACESO    = 4'd3;
    localparam logic [3:0] EST_APAGADO  = 4'd4;
    localparam logic [3:0] EST_FIM      = 4'd5;
    localparam logic [3:0] EST_ABORTADO = 4'd6;
    localparam int T_ON_PADRAO  = 500;
    localparam int T_OFF_PADRAO = 250;
    typedef enum logic [3:0] {
        OCIOSO   = EST_OCIOSO,
        ENDERECA = EST_ENDERECA,
        LE       = EST_LE,
        ACESO    = EST_ACESO,
        APAGADO  = EST_APAGADO,
        FIM      = EST_FIM,
        ABORTADO = EST_ABORTADO
    } estado_t;
endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M timer with clear and enable; fim flags the last count while enabled.
module contador_m #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa,
    input  logic         habilita,
    input  logic [W-1:0] modulo,
    output logic         fim
);
    logic [W-1:0] valor;
    assign fim = habilita && (valor == modulo - 1'b1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) valor <= '0;
        else if (limpa || fim) valor <= '0;
        else if (habilita) valor <= valor + 1'b1;
    end
endmodule

// File: rtl/mostra_sequencia.sv
// mostra_sequencia: replays stored plays 0..ultima_rodada on the LEDs, then pulses pronto.
// Define MOSTRA_SEQUENCIA_ABORTA_EN to add the abortar input and the ABORTADO state.
module mostra_sequencia
    import jogo_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int T_ON   = T_ON_PADRAO,
    parameter int T_OFF  = T_OFF_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
    input  logic              abortar,
`endif
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] ultima_rodada,
    output logic [ADDR_W-1:0] mem_endereco,
    input  logic [3:0]        mem_dado,
    output logic [3:0]        leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);
    localparam int TW = $clog2((T_ON > T_OFF ? T_ON : T_OFF) + 1);
    estado_t           estado;
    logic [ADDR_W-1:0] indice, limite;
    logic              aborta, temporiza, fim_tempo;
    logic [TW-1:0]     modulo;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
    assign aborta = abortar;
`else
    assign aborta = 1'b0;
`endif
    assign temporiza    = (estado == ACESO) || (estado == APAGADO);
    assign modulo       = (estado == ACESO) ? TW'(T_ON) : TW'(T_OFF);
    assign mem_endereco = indice;
    assign db_estado    = estado;

    contador_m #(.W(TW)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .limpa   (!temporiza),
        .habilita(temporiza),
        .modulo  (modulo),
        .fim     (fim_tempo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= OCIOSO;
            indice  <= '0;
            limite  <= '0;
            leds    <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            pronto <= 1'b0;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
            if (aborta && estado inside {ENDERECA, LE, ACESO, APAGADO}) begin
                estado <= ABORTADO;
                leds   <= '0;
            end else
`endif
            case (estado)
                OCIOSO: if (iniciar && !aborta) begin
                    estado  <= ENDERECA;
                    indice  <= '0;
                    limite  <= ultima_rodada;
                    ocupado <= 1'b1;
                end
                ENDERECA: estado <= LE;
                LE: begin
                    estado <= ACESO;
                    leds   <= mem_dado;
                end
                ACESO: if (fim_tempo) begin
                    estado <= APAGADO;
                    leds   <= '0;
                end
                APAGADO: if (fim_tempo) begin
                    if (indice == limite) begin
                        estado <= FIM;
                        pronto <= 1'b1;
                    end else begin
                        indice <= indice + 1'b1;
                        estado <= ENDERECA;
                    end
                end
                FIM: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
                ABORTADO: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
`endif
                default: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                    leds    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mostra_sequencia.sv
// tb_mostra_sequencia: per-cycle scoreboard of leds/pronto/ocupado/address/state for mostra_sequencia.
module tb_mostra_sequencia;
    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int PLAY  = 2 + T_ON + T_OFF;

    typedef struct packed {
        logic [3:0] leds;
        logic       pronto;
        logic       ocupado;
        logic [3:0] addr;
        logic [3:0] est;
    } exp_t;

    logic       clock, reset, iniciar, abortar;
    logic [3:0] ultima_rodada, mem_endereco, mem_dado, leds, db_estado;
    logic       ocupado, pronto;
    logic [3:0] mem [16];
    exp_t       q [$];
    int         checks, failures;

    mostra_sequencia #(.ADDR_W(4), .T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        .abortar      (abortar),
`endif
        .iniciar      (iniciar),
        .ultima_rodada(ultima_rodada),
        .mem_endereco (mem_endereco),
        .mem_dado     (mem_dado),
        .leds         (leds),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) mem_dado <= mem[mem_endereco];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".leds"}, int'(leds), 0);
        check({tag, ".ocupado"}, int'(ocupado), 0);
        check({tag, ".pronto"}, int'(pronto), 0);
        check({tag, ".estado"}, int'(db_estado), 0);
    endtask

    // Expected trace is built from the play table alone; cycle c is the c-th cycle after acceptance.
    task automatic run(input logic [3:0] last, input int perturb_at, input int stop_at);
        exp_t e;
        int   c;
        int   n;
        n = int'(last) + 1;
        @(negedge clock);
        iniciar = 1'b1;
        ultima_rodada = last;
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < PLAY; k++) begin
                e.addr    = p[3:0];
                e.pronto  = 1'b0;
                e.ocupado = 1'b1;
                e.leds    = (k >= 2 && k < 2 + T_ON) ? mem[p] : 4'd0;
                e.est     = k == 0 ? 4'd1 : k == 1 ? 4'd2 : k < 2 + T_ON ? 4'd3 : 4'd4;
                q.push_back(e);
            end
        end
        e = '{leds: 4'd0, pronto: 1'b1, ocupado: 1'b1, addr: last, est: 4'd5};
        q.push_back(e);
        e = '{leds: 4'd0, pronto: 1'b0, ocupado: 1'b0, addr: last, est: 4'd0};
        q.push_back(e);
        @(negedge clock);
        iniciar = 1'b0;
        c = 1;
        while (q.size() > 0) begin
            e = q.pop_front();
            check("leds", int'(leds), int'(e.leds));
            check("pronto", int'(pronto), int'(e.pronto));
            check("ocupado", int'(ocupado), int'(e.ocupado));
            check("mem_endereco", int'(mem_endereco), int'(e.addr));
            check("db_estado", int'(db_estado), int'(e.est));
            if (c == perturb_at) begin
                iniciar = 1'b1;
                ultima_rodada = ~last;
            end else if (c == perturb_at + 1) begin
                iniciar = 1'b0;
            end
            if (c == stop_at) q.delete();
            else begin
                @(negedge clock);
                c++;
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        iniciar = 1'b0;
        abortar = 1'b0;
        ultima_rodada = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        mem[0] = 4'b0001;
        mem[1] = 4'b0010;
        mem[2] = 4'b0100;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check_idle("reset_idle");
        end
        run(4'd2, 0, 0);
        mem[0] = 4'b1000;
        run(4'd0, 0, 0);
        mem[0] = 4'b0001;
        run(4'd2, 4, 0);
        // Stop inside play 1's lit window, then pull reset low between clock edges.
        run(4'd2, 0, 12);
        check("pre_reset.leds", int'(leds), 2);
        #1 reset = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset.addr", int'(mem_endereco), 0);
        #1 reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            check_idle("after_reset");
        end
        run(4'd2, 0, 0);
        for (int i = 0; i < 16; i++) mem[i] = i[3:0];
        run(4'd15, 0, 0);
        mem[0] = 4'b0000;
        mem[1] = 4'b1011;
        run(4'd1, 0, 0);
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        run(4'd2, 0, 7);
        abortar = 1'b1;
        @(negedge clock);
        abortar = 1'b0;
        check("abort.estado", int'(db_estado), 6);
        check("abort.leds", int'(leds), 0);
        check("abort.pronto", int'(pronto), 0);
        check("abort.ocupado", int'(ocupado), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_idle("abort_idle");
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mostra_sequencia.md
# mostra_sequencia

Sequence-display engine for the memory game. On a start pulse it reads stored plays from the play memory, address 0 up to the current round, and shows each one on the four LEDs for a programmable on-time, followed by a dark gap. It then pulses `pronto`. This is the game-to-player direction: it drives the `leds` the player watches before answering on `botoes`. It sits between the game FSM (which issues `iniciar`) and the synchronous play memory.

## Interface
- `ADDR_W`, 4: memory address width; max sequence length is 2^ADDR_W.
- `T_ON`, 500: cycles each play stays lit (0.5 s at 1 kHz); must be ≥ 1.
- `T_OFF`, 250: dark cycles after each play; must be ≥ 1.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `iniciar` in 1: start request, sampled in OCIOSO only.
- `ultima_rodada` in ADDR_W: last address to show, inclusive; sampled with `iniciar`.
- `mem_endereco` out ADDR_W: read address to play memory.
- `mem_dado` in 4: memory data, valid one cycle after address (synchronous read).
- `leds` out 4: registered LED drive.
- `ocupado` out 1: high from the cycle after `iniciar` is accepted until the return to OCIOSO.
- `pronto` out 1: single-cycle pulse in FIM.
- `db_estado` out 4: state code, for the 7-seg debug decoder.

## Operation
- States:
  - OCIOSO=0: idle.
  - ENDERECA=1: drives the address.
  - LE=2: memory latency cycle.
  - ACESO=3: play shown on `leds`.
  - APAGADO=4: dark gap.
  - FIM=5: completion pulse.
  - ABORTADO=6: only when the abort feature is compiled in.
- OCIOSO + `iniciar`=1 → ENDERECA. On the same edge: index←0, limit←`ultima_rodada`.
- ENDERECA → LE unconditionally. `mem_endereco` = index, held stable through LE and ACESO.
- LE → ACESO unconditionally. On that edge `leds`←`mem_dado`, and the timer clears.
- ACESO runs exactly T_ON cycles → APAGADO. On that edge `leds`←0 and the timer clears.
- APAGADO runs exactly T_OFF cycles.
  - If index == limit → FIM.
  - Otherwise index←index+1 → ENDERECA.
- FIM → OCIOSO. `pronto`=1 for exactly this cycle.
- Data 4'b0000 is still timed normally; it shows as dark.
- Multi-hot data is passed through unmodified.
- `iniciar` outside OCIOSO is ignored. It is not queued.
- `iniciar` held high across FIM restarts in the cycle after FIM returns to OCIOSO.
- `ultima_rodada` changes after acceptance have no effect.
- `ultima_rodada` = 2^ADDR_W−1 shows all addresses. The index never wraps.

## Timing
- Reset values: `leds`=0, `mem_endereco`=0, `ocupado`=0, `pronto`=0, `db_estado`=0, index=0, timer=0, state OCIOSO.
- Reset asserted mid-display clears all outputs immediately, asynchronously.
- Latency: `iniciar` sampled at edge 0 → first play visible after edge 2.
- Per play: 2 + T_ON + T_OFF cycles.
- `pronto` occurs N·(2+T_ON+T_OFF)+1 cycles after the acceptance edge, where N = limit+1.
- `ocupado` is registered, and is 0 in OCIOSO only.
- `leds` changes only on the LE→ACESO and ACESO→APAGADO edges.

## Configuration
- `MOSTRA_SEQUENCIA_ABORTA_EN` defined:
  - Adds input `abortar` (1 bit).
  - In any non-idle state except FIM, `abortar`=1 at an edge → ABORTADO, with `leds`←0. `pronto` does not pulse.
  - ABORTADO → OCIOSO next cycle, with `ocupado`=0 from then on.
  - `abortar` has priority over normal transitions on the same edge.
  - `abortar` in OCIOSO is ignored. It has priority over a simultaneous `iniciar`, so nothing starts.
- Undefined: no `abortar` port, no ABORTADO state. Code 6 is unused; an illegal state recovers to OCIOSO.

## Structure
- Shared package `jogo_pkg`:
  - state encoding localparams (the 4-bit codes above, shared with the `db_estado` decoder);
  - default T_ON/T_OFF constants.
- Sub-module `contador_m` (modulo-M timer with clear, enable and end-of-count flag):
  - one instance per duration, or one with a loadable modulus;
  - ACESO/APAGADO exit on its end-of-count flag.
- Index register and comparator are inline.

## Test plan
- Reset, no start: `leds`=0, `ocupado`=0, `db_estado`=0 for 50 cycles; then `reset`=0 for a partial cycle clears state asynchronously.
- T_ON=4, T_OFF=2, mem={0001,0010,0100}, `ultima_rodada`=2, `iniciar` pulse at edge 0:
  - `leds`=0001 in cycles 3–6, 0 in cycles 7–8;
  - 0010 in cycles 11–14;
  - 0100 in cycles 19–22;
  - `pronto`=1 only in cycle 25; `ocupado`=0 from cycle 26.
- `ultima_rodada`=0, mem[0]=1000: one play only, `mem_endereco` never leaves 0, `pronto` at cycle 9.
- `iniciar` re-pulsed during ACESO and `ultima_rodada` changed mid-run: sequence and length unchanged.
- Reset asserted during ACESO of play 1, then `iniciar`: restarts from address 0; no `pronto` from the aborted run.
- With `MOSTRA_SEQUENCIA_ABORTA_EN`: `abortar` in APAGADO of play 0 → next state ABORTADO (6), `leds`=0, no `pronto`, OCIOSO the following cycle.
